// File: rtl/map_tile_store.sv
// Tile memory for the maze: registered display read port, handshaked RMW write port, orb counter.
// Optional TILE_WALL_LOCK_EN: writes landing on a wall cell are acknowledged but discarded.
module map_tile_store #(
    parameter int MAP_W  = 21,
    parameter int MAP_H  = 21,
    parameter int TILE_W = 4
) (
    input  logic              clock_50,
    input  logic              resetn,
    input  logic              reload,
    input  logic [4:0]        rd_x,
    input  logic [4:0]        rd_y,
    output logic [TILE_W-1:0] rd_tile,
    input  logic              wr_req,
    input  logic [4:0]        wr_x,
    input  logic [4:0]        wr_y,
    input  logic [TILE_W-1:0] wr_tile,
    output logic              wr_ack,
    output logic              init_done,
    output logic [8:0]        orbs_left,
    output logic              level_clear
);

    localparam int unsigned CELLS = MAP_W * MAP_H;
    localparam int unsigned AW    = $clog2(CELLS);

    typedef enum logic [1:0] {INIT, IDLE, FETCH, COMMIT} state_e;

    state_e              state_q, state_d;
    logic [4:0]          ix_q, ix_d, iy_q, iy_d;
    logic                init_done_q, init_done_d;
    logic [8:0]          orbs_q, orbs_d;
    logic [TILE_W-1:0]   rd_tile_q, rd_tile_d;
    logic [4:0]          wx_q, wy_q;
    logic [TILE_W-1:0]   wt_q, old_q;
    logic [TILE_W-1:0]   mem_q [CELLS];

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [TILE_W-1:0]   mem_wdata;
    logic                commit, apply, lock, inc, dec;

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] x, input logic [4:0] y);
        return AW'(y) * AW'(MAP_W) + AW'(x);
    endfunction

    function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
        return (int'(x) < MAP_W) && (int'(y) < MAP_H);
    endfunction

    function automatic logic is_orb(input logic [TILE_W-1:0] t);
        return (t == TILE_W'(1)) || (t == TILE_W'(2));
    endfunction

    function automatic logic [TILE_W-1:0] default_tile(input logic [4:0] x, input logic [4:0] y);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        if (xi == 0 || yi == 0 || xi == MAP_W-1 || yi == MAP_H-1)
            return TILE_W'(3);
        else if ((xi == 1 || xi == MAP_W-2) && (yi == 1 || yi == MAP_H-2))
            return TILE_W'(1);
        else if (xi >= MAP_W/2-1 && xi <= MAP_W/2+1 && yi >= MAP_H/2-1 && yi <= MAP_H/2+1)
            return TILE_W'(4);
        else
            return TILE_W'(2);
    endfunction

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= INIT;
            ix_q        <= '0;
            iy_q        <= '0;
            init_done_q <= 1'b0;
            orbs_q      <= '0;
            rd_tile_q   <= '0;
            wx_q        <= '0;
            wy_q        <= '0;
            wt_q        <= '0;
        end else begin
            state_q     <= state_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            init_done_q <= init_done_d;
            orbs_q      <= orbs_d;
            rd_tile_q   <= rd_tile_d;
            if (state_q == IDLE && wr_req && !reload) begin
                wx_q <= wr_x;
                wy_q <= wr_y;
                wt_q <= wr_tile;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        init_done_d = init_done_q;
        if (reload) begin
            state_d     = INIT;
            ix_d        = '0;
            iy_d        = '0;
            init_done_d = 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (ix_q == 5'(MAP_W-1)) begin
                        ix_d = '0;
                        if (iy_q == 5'(MAP_H-1)) begin
                            iy_d        = '0;
                            state_d     = IDLE;
                            init_done_d = 1'b1;
                        end else begin
                            iy_d = iy_q + 5'd1;
                        end
                    end else begin
                        ix_d = ix_q + 5'd1;
                    end
                end
                IDLE:    if (wr_req) state_d = FETCH;
                FETCH:   state_d = COMMIT;
                COMMIT:  state_d = IDLE;
                default: state_d = INIT;
            endcase
        end
    end

    // A reload arriving in COMMIT abandons the write: no ack, no store, no count change.
    always_comb begin
        commit = (state_q == COMMIT) && !reload;
`ifdef TILE_WALL_LOCK_EN
        lock = (old_q == TILE_W'(3));
`else
        lock = 1'b0;
`endif
        apply = commit && in_range(wx_q, wy_q) && !lock;
        inc   = apply && !is_orb(old_q) && is_orb(wt_q);
        dec   = apply && is_orb(old_q) && !is_orb(wt_q) && (orbs_q != '0);

        wr_ack      = commit;
        level_clear = dec && (orbs_q == 9'd1);

        orbs_d = orbs_q;
        if (reload)
            orbs_d = '0;
        else if (state_q == INIT && is_orb(default_tile(ix_q, iy_q)))
            orbs_d = orbs_q + 9'd1;
        else if (inc)
            orbs_d = orbs_q + 9'd1;
        else if (dec)
            orbs_d = orbs_q - 9'd1;

        mem_we    = 1'b0;
        mem_waddr = cell_addr(wx_q, wy_q);
        mem_wdata = wt_q;
        if (state_q == INIT && !reload) begin
            mem_we    = 1'b1;
            mem_waddr = cell_addr(ix_q, iy_q);
            mem_wdata = default_tile(ix_q, iy_q);
        end else if (apply) begin
            mem_we = 1'b1;
        end

        rd_tile_d = '0;
        if (init_done_q && in_range(rd_x, rd_y))
            rd_tile_d = mem_q[cell_addr(rd_x, rd_y)];
    end

    always_ff @(posedge clock_50) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
        if (state_q == FETCH)
            old_q <= in_range(wx_q, wy_q) ? mem_q[cell_addr(wx_q, wy_q)] : '0;
    end

    assign rd_tile   = rd_tile_q;
    assign init_done = init_done_q;
    assign orbs_left = orbs_q;

endmodule

// File: doc/map_tile_store.md
Name: map_tile_store

Overview:
- Upstream tile memory for the 21x21 maze.
- Supplies the sprite type for each grid cell to the map display stage through a registered read port.
- Game logic updates cells through a write port with a request/acknowledge handshake, for example when Pac-Man eats an orb.
- Loads the default layout on reset or reload, counts the orbs remaining and flags when the level is cleared.

Parameters:
- MAP_W, 21, grid columns.
- MAP_H, 21, grid rows.
- TILE_W, 4, tile code width (0 black, 1 big orb, 2 small orb, 3 blue wall, 4 grey ghost-house).

Ports:
- clock_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- reload  in  1  synchronous request to re-run layout initialisation (new level).
- rd_x  in  5  display read column.
- rd_y  in  5  display read row.
- rd_tile  out  4  tile code at (rd_x, rd_y), registered.
- wr_req  in  1  write request; held high until wr_ack.
- wr_x  in  5  write column.
- wr_y  in  5  write row.
- wr_tile  in  4  new tile code.
- wr_ack  out  1  one-cycle pulse when the request is retired.
- init_done  out  1  high when the layout is loaded and writes are being served.
- orbs_left  out  9  count of cells holding code 1 or 2.
- level_clear  out  1  one-cycle pulse when orbs_left goes from 1 to 0.

Behaviour:
- Reset (resetn low, asynchronous): state INIT, init address 0, rd_tile=0, wr_ack=0, init_done=0, orbs_left=0, level_clear=0.
- Storage: 441 x 4-bit array, addressed as y*21+x.
  - One read port dedicated to the display.
  - One read-modify-write port for the write path.
- Read port:
  - rd_tile is registered with 1-cycle latency from rd_x/rd_y.
  - Out-of-range coordinates (x>20 or y>20) return 0.
  - rd_tile returns 0 while init_done=0.
  - A read and a write to the same cell in the same cycle returns the old value (read-before-write).
- States: INIT, IDLE, FETCH, COMMIT.
- INIT:
  - Walks addresses 0..440 in row-major order, one per cycle, writing the default layout:
    - border cells (x or y equal to 0 or 20) = 3;
    - (1,1), (19,1), (1,19), (19,19) = 1;
    - x and y both in 9..11 = 4;
    - all other cells = 2.
  - orbs_left counts up as orbs are written and ends at 352.
  - The cycle after address 440 is written: state IDLE, init_done=1.
  - Total time: 441 cycles from reset release or from reload.
- IDLE: on wr_req=1, latch wr_x, wr_y and wr_tile, then go to FETCH.
- FETCH: read the old code at the latched address, then go to COMMIT.
- COMMIT:
  - Write the new code and pulse wr_ack.
  - Adjust orbs_left: old orb and new non-orb -1; old non-orb and new orb +1; otherwise unchanged.
  - Go to IDLE.
  - Latency from wr_req sampled high to wr_ack is 2 cycles.
  - The requester must drop wr_req the cycle after wr_ack or it is served again.
- Out-of-range write: FETCH/COMMIT still run and wr_ack pulses, but storage and count are unchanged.
- level_clear: pulses in the COMMIT cycle whose decrement takes orbs_left from 1 to 0. Never pulses during INIT.
- orbs_left never underflows; a decrement at 0 is blocked.
- reload=1 in any state:
  - Next state INIT, address 0, orbs_left=0, init_done=0.
  - A write in flight is abandoned without wr_ack; a held wr_req is served after init completes.
  - reload has priority over a same-cycle wr_req.

Optional Feature:
- Macro: TILE_WALL_LOCK_EN.
- Defined: in COMMIT, if the old code is 3 (wall), the write is discarded. wr_ack still pulses and orbs_left is unchanged.
- Undefined: all in-range writes are applied.

Test Plan:
- Reset release, wait 441 cycles -> init_done=1 on cycle 442; orbs_left=352; reads return (0,0)=3, (1,1)=1, (10,10)=4, (5,5)=2, (25,3)=0.
- wr (5,5)<=0 -> wr_ack 2 cycles after wr_req; orbs_left=351; rd (5,5)=0 one cycle after address applied.
- wr (5,5)<=2, then wr (0,0)<=2 -> orbs_left back to 352, then 353 (macro undefined); with TILE_WALL_LOCK_EN, (0,0) stays 3 and orbs_left stays 352.
- Clear all 352 orbs with writes of 0 -> level_clear pulses exactly once, in the final COMMIT cycle; orbs_left=0; one extra orb-to-black write leaves the count at 0.
- reload asserted during FETCH -> no wr_ack; init_done drops next cycle; layout restored after 441 cycles; the held request is then acked.
- resetn pulsed low mid-INIT (asynchronously, between clock edges) -> all outputs 0 immediately; init restarts from address 0.
